cpu_uart_tx_responder: RTL and testbench

Memory-mapped bus responder on the CPU's single-cycle data bus (address, write data, data_rw, combinational read data), serving as the first peripheral target on that bus. It decodes a 16-byte register window and buffers CPU store bytes in a FIFO. A serializer FSM transmits each byte as 8N1 on a UART TX line at a programmable bit period. Top level muxes its read data into the CPU's data_in when hit is high.

---
 rtl/cpu_uart_tx_responder_pkg.sv | 12 +
 rtl/cpu_uart_tx_responder_if.sv | 10 +
 rtl/cpu_uart_tx_responder_fifo.sv | 37 +++
 rtl/cpu_uart_tx_responder.sv | 131 +++++++++++++
 tb/tb_cpu_uart_tx_responder.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/cpu_uart_tx_responder_pkg.sv
// cpu_uart_pkg: register offsets, STATUS bit positions and serializer states for the UART TX responder
package cpu_uart_pkg;
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;
    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_IRQ_EN = 4;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/cpu_uart_tx_responder_if.sv
// cpu_uart_tx_responder_if: single-cycle CPU data bus as seen by a memory-mapped responder
interface cpu_uart_tx_responder_if;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        data_rw;
    logic        hit;
    modport master (output address, wdata, data_rw, input rdata, hit);
    modport slave  (input address, wdata, data_rw, output rdata, hit);
endinterface

// File: rtl/cpu_uart_tx_responder_fifo.sv
// uart_byte_fifo: synchronous byte FIFO; pushes while full are dropped, dout shows the head entry
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= din;
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/cpu_uart_tx_responder.sv
// cpu_uart_tx_responder: 16-byte register window feeding a byte FIFO into an 8N1 UART serializer
// Optional UART_TX_IRQ_EN adds the irq output and STATUS.irq_enable.
module cpu_uart_tx_responder
    import cpu_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd103
) (
    input  logic                      clk,
    input  logic                      reset,
    cpu_uart_tx_responder_if.slave    bus,
`ifdef UART_TX_IRQ_EN
    output logic                      irq,
`endif
    output logic                      tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    state_t      state, state_n;
    logic [15:0] div, cnt, cnt_n;
    logic [7:0]  shift, shift_n, fifo_dout;
    logic [2:0]  idx, idx_n;
    logic [AW:0] count;
    logic [31:0] status;
    logic [1:0]  off;
    logic        ovf, irq_en, full, empty, we, push, pop, tx_n, expire;
    assign off     = bus.address[3:2];
    assign bus.hit = bus.address[31:4] == BASE_ADDR[31:4];
    assign we      = bus.hit && bus.data_rw;
    assign push    = we && off == OFF_DATA;
    assign expire  = cnt == '0;
    wire unused = &{1'b0, bus.address[1:0], bus.wdata[31:16]};
    always_comb begin
        status            = '0;
        status[ST_BUSY]   = state != IDLE;
        status[ST_FULL]   = full;
        status[ST_EMPTY]  = empty;
        status[ST_OVF]    = ovf;
        status[ST_IRQ_EN] = irq_en;
        status[15:8]      = 8'(count);
    end
    assign bus.rdata = !bus.hit ? '0 : off == OFF_STATUS ? status : off == OFF_DIV ? {16'h0, div} : '0;
    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (bus.wdata[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    // a dropped push and an overflow clear on the same edge leave overflow set
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= DIV_RESET;
            ovf <= 1'b0;
        end else begin
            if (we && off == OFF_DIV) div <= bus.wdata[15:0];
            ovf <= (push && full) || (ovf && !(we && off == OFF_STATUS && bus.wdata[ST_OVF]));
        end
    end
`ifdef UART_TX_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (we && off == OFF_STATUS) irq_en <= bus.wdata[ST_IRQ_EN];
            irq <= irq_en && empty && state == IDLE;
        end
    end
`else
    assign irq_en = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tx    <= 1'b1;
            shift <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            tx    <= tx_n;
            shift <= shift_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end
    // the counter reloads from div at every bit boundary, so div changes apply from the next bit
    always_comb begin
        state_n = state;
        tx_n    = tx;
        shift_n = shift;
        idx_n   = idx;
        cnt_n   = expire ? cnt : cnt - 16'd1;
        pop     = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                state_n = START;
                pop     = 1'b1;
                shift_n = fifo_dout;
                cnt_n   = div;
                tx_n    = 1'b0;
            end
            START: if (expire) begin
                state_n = DATA;
                tx_n    = shift[0];
                idx_n   = '0;
                cnt_n   = div;
            end
            DATA: if (expire) begin
                cnt_n   = div;
                state_n = idx == 3'd7 ? STOP : DATA;
                tx_n    = idx == 3'd7 ? 1'b1 : shift[1];
                shift_n = shift >> 1;
                idx_n   = idx + 3'd1;
            end
            STOP: if (expire) begin
                state_n = empty ? IDLE : START;
                pop     = !empty;
                shift_n = empty ? shift : fifo_dout;
                cnt_n   = div;
                tx_n    = empty;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cpu_uart_tx_responder.sv
// tb_cpu_uart_tx_responder: directed register checks plus a UART-decoding scoreboard on tx
module tb_cpu_uart_tx_responder;
    localparam logic [31:0] A_DATA   = 32'hF000_0000;
    localparam logic [31:0] A_STATUS = 32'hF000_0004;
    localparam logic [31:0] A_DIV    = 32'hF000_0008;
    localparam logic [31:0] A_RSV    = 32'hF000_000C;
    localparam logic [31:0] A_MISS   = 32'hF000_0010;
    logic clk = 1'b0;
    logic reset;
    logic tx;
`ifdef UART_TX_IRQ_EN
    logic irq;
`endif
    int checks = 0;
    int fails = 0;
    int bit_clks = 104;
    bit mon_en = 1'b1;
    logic [7:0] exp_q [$];
    logic [7:0] rx_b;
    cpu_uart_tx_responder_if bus ();
    cpu_uart_tx_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
`ifdef UART_TX_IRQ_EN
        .irq   (irq),
`endif
        .tx    (tx)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        bus.wdata   = d;
        bus.data_rw = 1'b1;
        @(posedge clk);
        #1 bus.data_rw = 1'b0;
    endtask
    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus.address = a;
        #1 chk(name, bus.rdata, exp);
    endtask
    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (bit_clks) @(posedge clk);
    endtask
    // receiver: samples each bit at its midpoint and scores the byte against the queue head
    initial forever begin
        @(negedge clk);
        if (mon_en && tx === 1'b0) begin
            repeat (bit_clks / 2) @(negedge clk);
            chk("start_bit", tx, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (bit_clks) @(negedge clk);
                rx_b[i] = tx;
            end
            repeat (bit_clks) @(negedge clk);
            chk("stop_bit", tx, 1);
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL rx_unexpected: got %h expected none", rx_b);
            end else chk("rx_byte", rx_b, exp_q.pop_front());
        end
    end
    initial begin
        #5_000_000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end
    initial begin
        reset = 1'b1;
        bus.address = '0;
        bus.wdata = '0;
        bus.data_rw = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        rd("rst_status", A_STATUS, 32'h0000_0004);
        rd("rst_data", A_DATA, 32'h0);
        rd("rst_div", A_DIV, 32'h0000_0067);
        chk("rst_tx", tx, 1);
        chk("rst_hit", bus.hit, 1);
        wr(A_DIV, 32'd3);
        bit_clks = 4;
        exp_q.push_back(8'hA5);
        wr(A_DATA, 32'hA5);
        @(posedge clk);
        #1 chk("tx_latency", tx, 0);
        repeat (39) @(posedge clk);
        #1 bus.address = A_STATUS;
        #1 chk("busy_n40", bus.rdata[0], 1);
        @(posedge clk);
        #1 chk("busy_n41", bus.rdata[0], 0);
        drain(200);
        wr(A_DIV, 32'd100);
        bit_clks = 101;
        for (int i = 1; i <= 18; i++) begin
            if (i < 18) exp_q.push_back(8'(8'h30 + i));
            wr(A_DATA, 32'h30 + i);
        end
        rd("st_full", A_STATUS, 32'h0000_100B);
        wr(A_STATUS, 32'h0);
        rd("ovf_keep", A_STATUS, 32'h0000_100B);
        wr(A_STATUS, 32'h8);
        rd("ovf_clear", A_STATUS, 32'h0000_1003);
        drain(20000);
        rd("st_idle", A_STATUS, 32'h0000_0004);
        wr(A_DIV, 32'd3);
        bit_clks = 4;
        mon_en = 1'b0;
        wr(A_DATA, 32'h00);
        repeat (18) @(posedge clk);
        #1 chk("tx_bit3", tx, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("tx_reset", tx, 1);
        reset = 1'b0;
        rd("rst2_status", A_STATUS, 32'h0000_0004);
        rd("rst2_div", A_DIV, 32'h0000_0067);
        @(negedge clk);
        bus.address = A_MISS;
        #1 chk("miss_hit", bus.hit, 0);
        chk("miss_rdata", bus.rdata, 0);
        rd("rsv_rdata", A_RSV, 32'h0);
        chk("rsv_hit", bus.hit, 1);
        wr(A_RSV, 32'hFFFF_FFFF);
        rd("rsv_wr_div", A_DIV, 32'h0000_0067);
        wr(A_MISS, 32'h55);
        rd("miss_wr_status", A_STATUS, 32'h0000_0004);
        repeat (3) @(posedge clk);
        #1 chk("miss_wr_tx", tx, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
